// File: rtl/video_window_conv_if.sv
// Purpose : bundles the window-in / pixel-out stream of video_window_conv.
// Latency : n/a (wires only).
// Backpressure: none; the stream is valid-only with no ready.
// Ports   : win_data_i/win_data_val_i/markers_i/coef_i flow toward the
//           filter, px_data_o/px_data_val_o/markers_o flow away from it.
//           master = upstream/observer side, slave = the filter itself.
interface video_window_conv_if #(
  parameter int PX_WIDTH   = 12,
  parameter int PX_PER_CLK = 4,
  parameter int WIN_SIZE   = 3,
  parameter int COEF_WIDTH = 8
);
  logic [PX_PER_CLK*WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] win_data_i;
  logic [PX_PER_CLK-1:0]                            win_data_val_i;
  logic                                             line_start_i;
  logic                                             line_end_i;
  logic                                             frame_start_i;
  logic                                             frame_end_i;
  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0]          coef_i;

  logic [PX_PER_CLK*PX_WIDTH-1:0]                   px_data_o;
  logic [PX_PER_CLK-1:0]                            px_data_val_o;
  logic                                             line_start_o;
  logic                                             line_end_o;
  logic                                             frame_start_o;
  logic                                             frame_end_o;

  modport master (
    output win_data_i, win_data_val_i, line_start_i, line_end_i,
           frame_start_i, frame_end_i, coef_i,
    input  px_data_o, px_data_val_o, line_start_o, line_end_o,
           frame_start_o, frame_end_o
  );

  modport slave (
    input  win_data_i, win_data_val_i, line_start_i, line_end_i,
           frame_start_i, frame_end_i, coef_i,
    output px_data_o, px_data_val_o, line_start_o, line_end_o,
           frame_start_o, frame_end_o
  );
endinterface

// File: rtl/video_window_conv.sv
// Purpose : per-lane WIN_SIZE x WIN_SIZE signed convolution with round/shift/saturate.
// Latency : 4 cycles input-to-output for data, lane valids and markers.
// Backpressure: none; every word with any lane valid is consumed, bubbles pass through.
// Ports   : clk_i, rst_i (sync, active-low); bus (slave modport) carries the
//           window stream, kernel coefficients and the filtered pixel stream.
module video_window_conv #(
  parameter int PX_WIDTH   = 12,
  parameter int PX_PER_CLK = 4,
  parameter int WIN_SIZE   = 3,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  video_window_conv_if.slave  bus
);

  localparam int TAPS = WIN_SIZE * WIN_SIZE;
  localparam int CTR  = (WIN_SIZE / 2) * WIN_SIZE + (WIN_SIZE / 2);
  localparam int PW   = PX_WIDTH + 1 + COEF_WIDTH;      // product width
  localparam int RW   = PW + $clog2(WIN_SIZE);          // row-sum width
  localparam int AW   = PW + $clog2(TAPS);              // full-sum width
  localparam int KW   = TAPS * COEF_WIDTH;
  localparam int NSTG = 4;

  // Half-LSB rounding constant; collapses to 0 when SHIFT is 0.
  localparam logic signed [AW:0] RND = (AW+1)'((1 << SHIFT) >> 1);
  // Identity kernel: unity gain (1<<SHIFT) on the centre tap only.
  localparam logic [KW-1:0] KERN_ID = KW'(1 << SHIFT) << (CTR * COEF_WIDTH);

  logic [KW-1:0]          kern_q, kern_d;
  logic                   kern_load;

  logic signed [PW-1:0]   prod_q [PX_PER_CLK][TAPS];
  logic signed [PW-1:0]   prod_d [PX_PER_CLK][TAPS];
  logic signed [RW-1:0]   row_q  [PX_PER_CLK][WIN_SIZE];
  logic signed [RW-1:0]   row_d  [PX_PER_CLK][WIN_SIZE];
  logic signed [AW-1:0]   acc_q  [PX_PER_CLK];
  logic signed [AW-1:0]   acc_d  [PX_PER_CLK];
  logic [PX_PER_CLK*PX_WIDTH-1:0] px_q, px_d;

  // Lane valids and {frame_end, frame_start, line_end, line_start} per stage.
  logic [PX_PER_CLK-1:0]  vld_q [NSTG];
  logic [PX_PER_CLK-1:0]  vld_d [NSTG];
  logic [3:0]             mk_q  [NSTG];
  logic [3:0]             mk_d  [NSTG];

  logic signed [PW-1:0]   px_ext, cf_ext;
  logic signed [AW:0]     rnd, shf;
  logic [PX_WIDTH-1:0]    sat;

  // Kernel swaps only on a real frame-start word, and that word already
  // uses the new kernel, so S1 multiplies by kern_d rather than kern_q.
  always_comb begin
    kern_load = bus.frame_start_i & (|bus.win_data_val_i);
    kern_d    = kern_load ? bus.coef_i : kern_q;
  end

  // Control pipeline: valids and markers ride alongside the data stages.
  always_comb begin
    vld_d[0] = bus.win_data_val_i;
    mk_d[0]  = {bus.frame_end_i, bus.frame_start_i, bus.line_end_i, bus.line_start_i};
    for (int s = 1; s < NSTG; s++) begin
      vld_d[s] = vld_q[s-1];
      mk_d[s]  = mk_q[s-1];
    end
  end

  // S1: pixels are unsigned, so zero-extend one bit before the signed multiply.
  always_comb begin
    px_ext = '0;
    cf_ext = '0;
    for (int l = 0; l < PX_PER_CLK; l++) begin
      for (int t = 0; t < TAPS; t++) begin
        px_ext = PW'({1'b0, bus.win_data_i[(l*TAPS + t)*PX_WIDTH +: PX_WIDTH]});
        cf_ext = PW'($signed(kern_d[t*COEF_WIDTH +: COEF_WIDTH]));
        prod_d[l][t] = px_ext * cf_ext;
      end
    end
  end

  // S2: one sum per kernel row.
  always_comb begin
    for (int l = 0; l < PX_PER_CLK; l++) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        row_d[l][r] = '0;
        for (int c = 0; c < WIN_SIZE; c++) begin
          row_d[l][r] = row_d[l][r] + RW'(prod_q[l][r*WIN_SIZE + c]);
        end
      end
    end
  end

  // S3: combine the row sums; AW is wide enough that this cannot overflow.
  always_comb begin
    for (int l = 0; l < PX_PER_CLK; l++) begin
      acc_d[l] = '0;
      for (int r = 0; r < WIN_SIZE; r++) begin
        acc_d[l] = acc_d[l] + AW'(row_q[l][r]);
      end
    end
  end

  // S4: round half up, arithmetic shift (floor), then clamp to pixel range.
  // Lanes that were not valid on input are forced to zero here.
  always_comb begin
    px_d = '0;
    rnd  = '0;
    shf  = '0;
    sat  = '0;
    for (int l = 0; l < PX_PER_CLK; l++) begin
      rnd = (AW+1)'(acc_q[l]) + RND;
      shf = rnd >>> SHIFT;
      if (!vld_q[2][l]) begin
        sat = '0;
      end else if (shf[AW]) begin
        sat = '0;
      end else if (|shf[AW-1:PX_WIDTH]) begin
        sat = '1;
      end else begin
        sat = shf[PX_WIDTH-1:0];
      end
      px_d[l*PX_WIDTH +: PX_WIDTH] = sat;
    end
  end

  // Everything clears on reset so in-flight words never surface afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      kern_q <= KERN_ID;
      px_q   <= '0;
      for (int l = 0; l < PX_PER_CLK; l++) begin
        acc_q[l] <= '0;
        for (int t = 0; t < TAPS; t++)     prod_q[l][t] <= '0;
        for (int r = 0; r < WIN_SIZE; r++) row_q[l][r]  <= '0;
      end
      for (int s = 0; s < NSTG; s++) begin
        vld_q[s] <= '0;
        mk_q[s]  <= '0;
      end
    end else begin
      kern_q <= kern_d;
      px_q   <= px_d;
      for (int l = 0; l < PX_PER_CLK; l++) begin
        acc_q[l] <= acc_d[l];
        for (int t = 0; t < TAPS; t++)     prod_q[l][t] <= prod_d[l][t];
        for (int r = 0; r < WIN_SIZE; r++) row_q[l][r]  <= row_d[l][r];
      end
      for (int s = 0; s < NSTG; s++) begin
        vld_q[s] <= vld_d[s];
        mk_q[s]  <= mk_d[s];
      end
    end
  end

  assign bus.px_data_o     = px_q;
  assign bus.px_data_val_o = vld_q[NSTG-1];
  assign bus.line_start_o  = mk_q[NSTG-1][0];
  assign bus.line_end_o    = mk_q[NSTG-1][1];
  assign bus.frame_start_o = mk_q[NSTG-1][2];
  assign bus.frame_end_o   = mk_q[NSTG-1][3];

endmodule

// File: tb/tb_video_window_conv.sv
// Purpose : directed checks of video_window_conv against hand-computed results.
// Latency : expects every word's result 4 cycles after it is driven.
// Backpressure: none; outputs are compared every cycle, default expectation all-zero.
module tb_video_window_conv;

  localparam int WB = 4*9*12;
  localparam logic [71:0] K_ID  = 72'h000000001000000000;
  localparam logic [71:0] K_BOX = 72'h010101010101010101;
  localparam logic [71:0] K_16  = 72'h101010101010101010;
  localparam logic [71:0] K_NEG = 72'h00000000F000000000;
  localparam logic [3:0]  LS = 4'b0001, LE = 4'b0010, FS = 4'b0100, FE = 4'b1000;
  localparam logic [3:0]  ALL = 4'b1111;

  logic clk = 1'b0;
  logic rst_i;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  logic [47:0] exp_dat [int];
  logic [3:0]  exp_vld [int];
  logic [3:0]  exp_mk  [int];

  video_window_conv_if #(.PX_WIDTH(12), .PX_PER_CLK(4), .WIN_SIZE(3), .COEF_WIDTH(8)) bus ();

  video_window_conv #(
    .PX_WIDTH(12), .PX_PER_CLK(4), .WIN_SIZE(3), .COEF_WIDTH(8), .SHIFT(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [47:0] ed;
    logic [3:0]  ev, em;
    if (!chk_en) return;
    ed = exp_dat.exists(cyc) ? exp_dat[cyc] : 48'h0;
    ev = exp_vld.exists(cyc) ? exp_vld[cyc] : 4'h0;
    em = exp_mk.exists(cyc)  ? exp_mk[cyc]  : 4'h0;
    check($sformatf("dat@%0d", cyc), bus.px_data_o, ed);
    check($sformatf("vld@%0d", cyc), 48'(bus.px_data_val_o), 48'(ev));
    check($sformatf("mk@%0d", cyc),
          48'({bus.frame_end_o, bus.frame_start_o, bus.line_end_o, bus.line_start_o}),
          48'(em));
    exp_dat.delete(cyc);
    exp_vld.delete(cyc);
    exp_mk.delete(cyc);
  endtask

  function automatic logic [WB-1:0] ramp(input logic [11:0] base);
    logic [WB-1:0] w;
    w = '0;
    for (int l = 0; l < 4; l++)
      for (int t = 0; t < 9; t++)
        w[(l*9 + t)*12 +: 12] = base + 12'(l*256) + 12'(t);
    return w;
  endfunction

  function automatic logic [WB-1:0] flat(input logic [11:0] v);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < 36; i++) w[i*12 +: 12] = v;
    return w;
  endfunction

  function automatic logic [WB-1:0] one_tap(input logic [11:0] v, input int tap);
    logic [WB-1:0] w;
    w = '0;
    for (int l = 0; l < 4; l++) w[(l*9 + tap)*12 +: 12] = v;
    return w;
  endfunction

  // Drive one word at the falling edge and record what must appear 4 cycles later.
  task automatic drive(input logic [WB-1:0] win, input logic [3:0] vld, input logic [3:0] mk,
                       input logic [71:0] coef, input logic [47:0] edat);
    @(negedge clk);
    check_cycle();
    rst_i              = 1'b1;
    bus.win_data_i     = win;
    bus.win_data_val_i = vld;
    bus.line_start_i   = mk[0];
    bus.line_end_i     = mk[1];
    bus.frame_start_i  = mk[2];
    bus.frame_end_i    = mk[3];
    bus.coef_i         = coef;
    if ((|vld) || (|mk)) begin
      exp_dat[cyc+4] = edat;
      exp_vld[cyc+4] = vld;
      exp_mk[cyc+4]  = mk;
    end
  endtask

  // Hold reset with live-looking garbage on the inputs; nothing may come out.
  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
      rst_i              = 1'b0;
      bus.win_data_i     = flat(12'h5A5);
      bus.win_data_val_i = 4'hF;
      {bus.frame_end_i, bus.frame_start_i, bus.line_end_i, bus.line_start_i} = ALL;
      bus.coef_i         = K_16;
      exp_dat.delete();
      exp_vld.delete();
      exp_mk.delete();
    end
  endtask

  initial begin
    logic [WB-1:0] w, g;
    rst_i              = 1'b0;
    bus.win_data_i     = '0;
    bus.win_data_val_i = '0;
    bus.line_start_i   = 1'b0;
    bus.line_end_i     = 1'b0;
    bus.frame_start_i  = 1'b0;
    bus.frame_end_i    = 1'b0;
    bus.coef_i         = '0;

    rst_cycles(2);
    chk_en = 1'b1;
    rst_cycles(2);

    // 1: identity kernel passes each lane's centre pixel; mid-frame coef ignored.
    drive(ramp(12'h11F), 4'hF, FS|LS, K_ID,  48'h423323223123);
    drive(ramp(12'h11F), 4'hF, 4'h0,  K_BOX, 48'h423323223123);
    drive(flat(12'hABC), 4'h0, 4'h0,  K_BOX, 48'h0);
    drive(ramp(12'h11F), 4'hF, LE|FE, K_ID,  48'h423323223123);

    // 2: box kernel, including the round-half-up boundary (7 -> 0, 8 -> 1).
    drive(flat(12'h100),        4'hF, FS|LS, K_BOX, 48'h090090090090);
    drive(one_tap(12'h008, 0),  4'hF, 4'h0,  K_BOX, 48'h001001001001);
    drive(one_tap(12'h007, 0),  4'hF, 4'h0,  K_BOX, 48'h000000000000);
    drive(one_tap(12'h080, 4),  4'hF, LE|FE, K_BOX, 48'h008008008008);

    // 3: saturation high, then a single-word frame saturating low.
    drive(flat(12'hFFF), 4'hF, FS|LS,       K_16,  48'hFFFFFFFFFFFF);
    drive(flat(12'h800), 4'hF, FS|FE|LS|LE, K_NEG, 48'h000000000000);

    // 4: coef change at line 5 is held off until the next frame-start word.
    drive(flat(12'h100), 4'hF, FS|LS, K_BOX, 48'h090090090090);
    for (int line = 1; line <= 5; line++)
      drive(flat(12'h100), 4'hF, LS|LE, (line == 5) ? K_ID : K_BOX, 48'h090090090090);
    drive(flat(12'h100), 4'hF, LE|FE, K_ID, 48'h090090090090);
    // frame_start on a bubble must not load the kernel
    drive(flat(12'h777), 4'h0, FS,    K_16, 48'h0);
    drive(flat(12'h100), 4'hF, 4'h0,  K_ID, 48'h090090090090);
    drive(flat(12'h100), 4'hF, FS|LS, K_ID, 48'h100100100100);
    drive(flat(12'h100), 4'hF, FE,    K_BOX, 48'h100100100100);

    // 5: partial last word; garbage on lanes 2-3 must be zeroed.
    drive(flat(12'h100), 4'hF, FS|LS, K_BOX, 48'h090090090090);
    w = flat(12'h100);
    g = flat(12'hFFF);
    w[WB-1:WB/2] = g[WB-1:WB/2];
    drive(w, 4'b0011, LE|FE, K_BOX, 48'h000000090090);

    // 6: reset mid-line with words in flight; kernel returns to identity.
    drive(flat(12'h100), 4'hF, FS|LS, K_BOX, 48'h090090090090);
    drive(flat(12'h100), 4'hF, 4'h0,  K_BOX, 48'h090090090090);
    drive(flat(12'h100), 4'hF, 4'h0,  K_BOX, 48'h090090090090);
    rst_cycles(2);
    drive(ramp(12'h11F), 4'hF, 4'h0,  K_BOX, 48'h423323223123);
    drive(flat(12'h100), 4'hF, FS|LS, K_BOX, 48'h090090090090);
    drive(flat(12'h100), 4'hF, LE|FE, K_BOX, 48'h090090090090);

    for (int i = 0; i < 6; i++) drive('0, 4'h0, 4'h0, K_ID, 48'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
